// File: rtl/i2s_dac_tx_if.sv
// Sample-pair handshake between the audio source and the I2S transmitter.
interface i2s_dac_tx_if #(
    parameter int SAMPLE_W = 16
);
    logic [SAMPLE_W-1:0] SampleL;
    logic [SAMPLE_W-1:0] SampleR;
    logic                SampleValid;
    logic                SampleReady;

    modport master (output SampleL, SampleR, SampleValid, input SampleReady);
    modport slave  (input SampleL, SampleR, SampleValid, output SampleReady);
endinterface

// File: rtl/i2s_dac_tx.sv
// Philips I2S transmitter: buffers stereo pairs in a small FIFO and serialises
// them MSB first with a one-slot data delay, muting and counting underruns.
module i2s_dac_tx #(
    parameter int CLK_DIV    = 35,
    parameter int SAMPLE_W   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Enable,
    i2s_dac_tx_if.slave samples,
    output logic        DAC_I2S_CLK,
    output logic        DAC_I2S_WS,
    output logic        DAC_I2S_DATA,
    output logic        Underrun,
    output logic [15:0] UnderrunCount
);
    localparam int FRAME_W = 2 * SAMPLE_W;
    localparam int SLOT_W  = $clog2(FRAME_W);
    localparam int ADDR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = ADDR_W + 1;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q, state_d;

    logic [FRAME_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   fill_q;
    logic               fifo_empty, fifo_full, push, pop;

    logic [DIV_W-1:0]   div_q;
    logic               bclk_q;
    logic [SLOT_W-1:0]  slot_q;
    logic [FRAME_W-1:0] shift_q;
    logic [15:0]        underrun_count_q;
    logic               div_tick, bclk_fall, start_load, wrap_load, frame_load;
    logic [FRAME_W-1:0] load_word;

    assign fifo_empty          = (fill_q == '0);
    assign fifo_full           = (fill_q == CNT_W'(FIFO_DEPTH));
    assign samples.SampleReady = !fifo_full;
    assign push                = samples.SampleValid && !fifo_full;
    assign frame_load          = start_load || wrap_load;
    assign pop                 = frame_load && !fifo_empty;
    assign load_word           = fifo_empty ? '0 : fifo_mem[rd_ptr_q];
    assign UnderrunCount       = underrun_count_q;

    // NOTE: the storage array has no reset; flushing clears pointers and fill
    // count, which alone decide what can be read.
    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr_q] <= {samples.SampleL, samples.SampleR};
    end

    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            fill_q <= fill_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        div_tick   = 1'b0;
        bclk_fall  = 1'b0;
        start_load = 1'b0;
        wrap_load  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Enable) begin
                    state_d    = RUN;
                    start_load = 1'b1;
                end
            end
            RUN: begin
                if (!Enable) begin
                    state_d = IDLE;
                end else begin
                    div_tick  = (div_q == DIV_W'(CLK_DIV - 1));
                    bclk_fall = div_tick && bclk_q;
                    wrap_load = bclk_fall && (slot_q == SLOT_W'(FRAME_W - 1));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            div_q            <= '0;
            bclk_q           <= 1'b0;
            slot_q           <= '0;
            shift_q          <= '0;
            DAC_I2S_CLK      <= 1'b0;
            DAC_I2S_WS       <= 1'b0;
            DAC_I2S_DATA     <= 1'b0;
            Underrun         <= 1'b0;
            underrun_count_q <= '0;
        end else if (state_d == IDLE) begin
            div_q        <= '0;
            bclk_q       <= 1'b0;
            slot_q       <= '0;
            shift_q      <= '0;
            DAC_I2S_CLK  <= 1'b0;
            DAC_I2S_WS   <= 1'b0;
            DAC_I2S_DATA <= 1'b0;
            Underrun     <= 1'b0;
        end else begin
            DAC_I2S_CLK <= bclk_q;
            Underrun    <= frame_load && fifo_empty;
            if (frame_load && fifo_empty && underrun_count_q != 16'hFFFF)
                underrun_count_q <= underrun_count_q + 16'd1;
            if (state_q == RUN) div_q <= div_tick ? '0 : div_q + DIV_W'(1);
            if (div_tick) bclk_q <= !bclk_q;
            if (start_load) shift_q <= load_word;
            // WS and DATA move only on the falling toggle, so the DAC sees them settled at its rising edge.
            if (bclk_fall) begin
                slot_q       <= wrap_load ? '0 : slot_q + SLOT_W'(1);
                DAC_I2S_WS   <= (slot_q >= SLOT_W'(SAMPLE_W - 1)) && !wrap_load;
                DAC_I2S_DATA <= shift_q[FRAME_W-1];
                shift_q      <= wrap_load ? load_word : {shift_q[FRAME_W-2:0], 1'b0};
            end
        end
    end
endmodule

// File: doc/i2s_dac_tx.md
Name: i2s_dac_tx

Overview:
- Audio output stage between the audio sample source inside the audio/video core and the external I2S DAC pins.
- Accepts stereo PCM sample pairs over a valid/ready handshake and buffers them in a small FIFO.
- Generates the DAC bit clock, word select and serial data in Philips I2S format: MSB first, data delayed one bit clock after each word-select edge.
- Mutes and flags an underrun when no sample pair is available at a frame boundary.

Parameters:
- CLK_DIV, 35, CLK cycles per bit-clock half period; BCLK = f(CLK)/(2*CLK_DIV); legal range 1 or more.
- SAMPLE_W, 16, bits per channel sample; frame = 2*SAMPLE_W bit slots.
- FIFO_DEPTH, 4, sample-pair FIFO entries; power of two, 2 or more.

Ports:
- CLK  in  1  system clock; sole clock domain.
- Reset  in  1  asynchronous, active-high reset.
- Enable  in  1  run/stop for the serial interface.
- SampleL  in  SAMPLE_W  left sample, two's complement.
- SampleR  in  SAMPLE_W  right sample, two's complement.
- SampleValid  in  1  sample pair present.
- SampleReady  out  1  FIFO can accept; equals not-full.
- DAC_I2S_CLK  out  1  bit clock.
- DAC_I2S_WS  out  1  word select; 0 = left, 1 = right.
- DAC_I2S_DATA  out  1  serial data.
- Underrun  out  1  one-CLK pulse per muted frame.
- UnderrunCount  out  16  saturating count of muted frames.

Behaviour:
- Reset asserted, at any time including mid-frame, immediately forces these values:
  - DAC_I2S_CLK, DAC_I2S_WS, DAC_I2S_DATA = 0.
  - Underrun = 0, UnderrunCount = 0.
  - FIFO flushed (empty).
  - Divider and slot counters = 0.
- SampleReady is combinational from FIFO full, so it reads 1 during and after Reset.
- FIFO behaviour:
  - Push when SampleValid and SampleReady are both high on a CLK edge; stores {SampleL, SampleR}.
  - Pop only at frame load. There is no fall-through: a push and a load on the same edge with the FIFO empty counts as an underrun, and the pushed pair is kept for the next frame.
  - When full, SampleReady = 0. After a pop, SampleReady rises in the following cycle.
  - The FIFO keeps accepting pushes while Enable = 0.
- Bit clock:
  - Divider counts 0..CLK_DIV-1; at terminal count it wraps and toggles an internal BCLK.
  - DAC_I2S_CLK is a registered copy of the internal BCLK.
  - All WS/DATA updates occur on the CLK cycle of a BCLK falling toggle, so they are stable across the DAC's rising-edge sample point.
- Slot counter s (0..2*SAMPLE_W-1):
  - Advances on each BCLK falling toggle and wraps to 0.
  - WS = 0 for s in 0..SAMPLE_W-1; WS = 1 for s in SAMPLE_W..2*SAMPLE_W-1.
- Data:
  - DATA is a 2*SAMPLE_W-bit shift register MSB-first stream, delayed one slot.
  - The left MSB appears in slot 1; the right LSB of a frame appears in slot 0 of the next frame.
  - Bits are transmitted unmodified; no sign or width conversion.
- Frame load happens at the falling toggle where s wraps to 0:
  - If the FIFO is non-empty, pop into the shift register.
  - If empty, load all zeros, pulse Underrun for one CLK, and increment UnderrunCount, saturating at 0xFFFF.
- State machine:
  - IDLE: entered from reset or when Enable = 0. Outputs DAC_I2S_CLK, WS and DATA all 0; divider and slot counter cleared; delayed-data register cleared.
  - RUN: entered when Enable = 1 is sampled in IDLE. First edge performs a frame load with s = 0, then runs continuously.
  - RUN -> IDLE occurs on the CLK edge after Enable is sampled 0, at any point in the frame. The current frame is abandoned and its popped pair is discarded.
  - Re-enable always restarts at slot 0 with WS = 0.
- Latency: first BCLK rising edge occurs CLK_DIV+1 CLK cycles after Enable is sampled high.

Test Plan:
- Reset mid-frame (CLK_DIV=2, SAMPLE_W=16): assert Reset during slot 20 -> all outputs 0 in the same cycle; after release SampleReady = 1 and UnderrunCount = 0.
- Single frame: push L=0xA5C3, R=0x0F01, then Enable=1 -> BCLK period 4 CLK; WS low for 16 slots then high; DATA on 32 rising edges = 0 then 1010010111000011 then 000011110000000 (first 15 bits of R); R's LSB 1 arrives in slot 0 of next frame.
- Underrun: Enable with empty FIFO -> DATA all 0, one Underrun pulse per 128-CLK frame; after 3 frames UnderrunCount = 3. Then push one pair -> next frame carries it and no pulse.
- Full FIFO: push 5 pairs with Enable=0 -> SampleReady drops after the 4th and the 5th is held off. Enable -> first load pops, SampleReady = 1 next cycle, 5th accepted; output order preserved.
- Enable drop at slot 9 -> next cycle DAC_I2S_CLK/WS/DATA = 0. Re-enable -> restarts with WS=0; the pair interrupted at slot 9 is not retransmitted; the following FIFO pair is sent.
- Saturation: force 65537 underrun frames (or preload the count in sim) -> UnderrunCount holds 0xFFFF; Underrun pulses continue.
